clk_div_gen: RTL and testbench

- Parametrised integer clock divider with built-in bypass, enable, and glitch-free ratio and mode switching.
- Successor to the fixed 8-bit ratio-select output mux: generates the divided clock itself, applies ratio changes only at period boundaries, and never emits runt pulses.
- Sits at the root of each derived clock domain, driven by the reference clock and a software-programmed ratio.

---
 rtl/clk_div_pkg.sv | 24 ++
 rtl/clk_div_gen_clk_out_mux.sv | 13 +
 rtl/clk_div_gen.sv | 117 +++++++++++
 tb/tb_clk_div_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and phase-length helpers for the clk_div_gen clock divider.
`timescale 1ns/1ps
package clk_div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HIGH  = 3'd1,
    LOW   = 3'd2,
    BYP   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // Ratios at or below this value select the reference-clock bypass.
  localparam int BYP_MAX_RATIO = 1;

  function automatic logic [31:0] high_len(input logic [31:0] ratio);
    return ratio >> 1;
  endfunction

  function automatic logic [31:0] low_len(input logic [31:0] ratio);
    return ratio - (ratio >> 1);
  endfunction

endpackage

// File: rtl/clk_div_gen_clk_out_mux.sv
// Leaf 2:1 clock select with reset force-low; stand-in for a library clock-mux cell.
`timescale 1ns/1ps
module clk_out_mux (
  input  logic i_ref_clk,
  input  logic i_rst,
  input  logic i_sel,
  input  logic i_div,
  output logic o_clk
);

  assign o_clk = i_rst ? 1'b0 : (i_sel ? i_ref_clk : i_div);

endmodule

// File: rtl/clk_div_gen.sv
// Integer clock divider with bypass, enable and glitch-free ratio/mode switching.
`timescale 1ns/1ps
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             i_ref_clk,
  input  logic             i_rst,
  input  logic             i_clk_en,
  input  logic [DIV_W-1:0] i_div_ratio,
  output logic             o_div_clk,
  output logic [DIV_W-1:0] o_active_ratio,
  output logic             o_upd,
  output logic [2:0]       o_dbg_state
);

  localparam logic [DIV_W-1:0] BYP_MAX = DIV_W'(BYP_MAX_RATIO);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  state_t           state_q, state_d;
  logic             div_q, div_d;
  logic             byp_q, byp_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] act_prev_q;
  logic             upd_q;
  logic             boundary;
  logic [DIV_W-1:0] hi_m1, lo_m1;

  assign hi_m1 = DIV_W'(high_len(32'(act_q)) - 32'd1);
  assign lo_m1 = DIV_W'(low_len(32'(act_q)) - 32'd1);

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      div_q      <= 1'b0;
      byp_q      <= 1'b0;
      cnt_q      <= '0;
      act_q      <= '0;
      act_prev_q <= '0;
      upd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      byp_q      <= byp_d;
      cnt_q      <= cnt_d;
      act_q      <= act_d;
      act_prev_q <= act_q;
      upd_q      <= (act_q != act_prev_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    byp_d    = byp_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    boundary = 1'b0;
    case (state_q)
      IDLE: boundary = 1'b1;
      HIGH: begin
        if (cnt_q == hi_m1) begin
          state_d = LOW;
          div_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      LOW: begin
        if (cnt_q == lo_m1) boundary = 1'b1;
        else                cnt_d = cnt_q + ONE;
      end
      BYP: boundary = 1'b1;
      DRAIN: begin
        state_d = IDLE;
        div_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Inputs are only ever consumed here, so mid-period changes never shorten a phase.
    if (boundary) begin
      act_d = i_div_ratio;
      cnt_d = '0;
      byp_d = 1'b0;
      if (!i_clk_en) begin
        // Leaving bypass holds high one full cycle so the last pulse is not a runt.
        state_d = (state_q == BYP) ? DRAIN : IDLE;
        div_d   = (state_q == BYP);
      end else if (i_div_ratio <= BYP_MAX) begin
        state_d = BYP;
        byp_d   = 1'b1;
        div_d   = 1'b0;
      end else begin
        state_d = HIGH;
        div_d   = 1'b1;
      end
    end
  end

  always_comb begin
    o_active_ratio = act_q;
    o_upd          = upd_q;
    o_dbg_state    = state_q;
  end

  clk_out_mux u_clk_out_mux (
    .i_ref_clk (i_ref_clk),
    .i_rst     (i_rst),
    .i_sel     (byp_q),
    .i_div     (div_q),
    .o_clk     (o_div_clk)
  );

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: period-level reference model plus directed pins.
`timescale 1ns/1ps
module tb_clk_div_gen;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] ratio;
  logic         div_clk;
  logic [W-1:0] act_ratio;
  logic         upd;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_gen #(.DIV_W(W)) dut (
    .i_ref_clk      (clk),
    .i_rst          (rst),
    .i_clk_en       (en),
    .i_div_ratio    (ratio),
    .o_div_clk      (div_clk),
    .o_active_ratio (act_ratio),
    .o_upd          (upd),
    .o_dbg_state    (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: per-cycle output queue (0, 1, or 2 = follows ref clock),
  // refilled one whole period at a time whenever the previous period has ended.
  logic [1:0]   exp_q[$];
  logic [1:0]   exp_div;
  logic [W-1:0] cur_act, prev_act;
  logic         exp_upd;
  logic         in_byp;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_div  = 2'd0;
      cur_act  = '0;
      prev_act = '0;
      exp_upd  = 1'b0;
      in_byp   = 1'b0;
    end else begin
      exp_upd  = (cur_act != prev_act);
      prev_act = cur_act;
      if (exp_q.size() == 0) begin
        cur_act = ratio;
        if (!en) begin
          if (in_byp) begin
            exp_q.push_back(2'd1);
            exp_q.push_back(2'd0);
          end else begin
            exp_q.push_back(2'd0);
          end
          in_byp = 1'b0;
        end else if (ratio <= 1) begin
          exp_q.push_back(2'd2);
          in_byp = 1'b1;
        end else begin
          for (int i = 0; i < int'(ratio) / 2; i++) exp_q.push_back(2'd1);
          for (int i = 0; i < int'(ratio) - int'(ratio) / 2; i++) exp_q.push_back(2'd0);
          in_byp = 1'b0;
        end
      end
      exp_div = exp_q.pop_front();
    end
    // compare process: ref-high half, then ref-low half
    #1;
    check("div_hi", int'(div_clk), rst ? 0 : (exp_div == 2'd2 ? 1 : int'(exp_div)));
    check("act_ratio", int'(act_ratio), rst ? 0 : int'(cur_act));
    check("upd", int'(upd), rst ? 0 : int'(exp_upd));
    @(negedge clk);
    #1;
    check("div_lo", int'(div_clk), rst ? 0 : (exp_div == 2'd2 ? 0 : int'(exp_div)));
  end

  // driver tasks
  logic s;

  task automatic sample();
    @(posedge clk);
    #2;
    s = div_clk;
  endtask

  task automatic drive(input logic e, input logic [W-1:0] r);
    @(negedge clk);
    en    = e;
    ratio = r;
  endtask

  task automatic measure(output int hi, output int lo);
    int budget;
    budget = 700;
    hi = 0;
    lo = 0;
    while (s == 1'b0 && budget > 0) begin sample(); budget--; end
    while (s == 1'b1 && budget > 0) begin hi++; sample(); budget--; end
    while (s == 1'b0 && budget > 0) begin lo++; sample(); budget--; end
    if (budget == 0) check("measure_timeout", 0, 1);
  endtask

  initial begin
    int hi, lo, cnt;
    logic [7:0] pat;
    rst   = 1'b1;
    en    = 1'b0;
    ratio = '0;
    s     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check("reset_div", int'(div_clk), 0);
    check("reset_act", int'(act_ratio), 0);
    check("reset_upd", int'(upd), 0);

    // ratio 4 from reset
    @(negedge clk);
    ratio = 8'd4;
    en    = 1'b1;
    rst   = 1'b0;
    pat = '0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      sample();
      pat = {pat[6:0], s};
      if (upd) cnt++;
    end
    check("r4_pattern", int'(pat), 8'b1100_1100);
    check("r4_upd_pulses", cnt, 1);
    check("r4_act", int'(act_ratio), 4);

    // ratio 5, then 6 written mid-high
    drive(1'b1, 8'd5);
    measure(hi, lo);
    measure(hi, lo);
    check("r5_hi", hi, 2);
    check("r5_lo", lo, 3);
    drive(1'b1, 8'd6);
    measure(hi, lo);
    check("r5to6_hi", hi, 2);
    check("r5to6_lo", lo, 3);
    measure(hi, lo);
    check("r6_hi", hi, 3);
    check("r6_lo", lo, 3);

    // ratio 3 then bypass via ratio 1
    drive(1'b1, 8'd3);
    measure(hi, lo);
    measure(hi, lo);
    check("r3_hi", hi, 1);
    check("r3_lo", lo, 2);
    drive(1'b1, 8'd1);
    repeat (4) sample();
    check("byp_hi", int'(s), 1);
    @(negedge clk);
    #2;
    check("byp_lo", int'(div_clk), 0);
    check("byp_act", int'(act_ratio), 1);

    // bypass ratio 0 to ratio 2
    drive(1'b1, 8'd0);
    repeat (2) @(posedge clk);
    drive(1'b1, 8'd2);
    sample();
    @(negedge clk);
    #2;
    check("byp2_full_high", int'(div_clk), 1);
    pat = '0;
    for (int i = 0; i < 4; i++) begin sample(); pat = {pat[6:0], s}; end
    check("r2_pattern", int'(pat[3:0]), 4'b0101);

    // bypass then disable: one full-cycle drain pulse, then steady low
    drive(1'b1, 8'd0);
    repeat (6) @(posedge clk);
    drive(1'b0, 8'd0);
    sample();
    check("drain_hi", int'(s), 1);
    @(negedge clk);
    #2;
    check("drain_lo_half", int'(div_clk), 1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin sample(); if (s) cnt++; end
    check("drain_then_idle", cnt, 0);

    // ratio 7, disable mid-high
    drive(1'b1, 8'd7);
    sample();
    measure(hi, lo);
    check("r7_hi", hi, 3);
    check("r7_lo", lo, 4);
    drive(1'b0, 8'd7);
    hi = 0;
    while (s == 1'b1 && hi < 20) begin hi++; sample(); end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin if (s) cnt++; sample(); end
    check("r7_last_hi", hi, 3);
    check("r7_held_low", cnt, 0);
    drive(1'b1, 8'd7);
    sample();
    check("r7_restart", int'(s), 1);

    // reset mid-high with ratio 255
    drive(1'b1, 8'd255);
    sample();
    measure(hi, lo);
    sample();
    #1;
    rst = 1'b1;
    #1;
    check("rst_div_now", int'(div_clk), 0);
    check("rst_act_now", int'(act_ratio), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sample();
    measure(hi, lo);
    check("r255_hi", hi, 127);
    check("r255_lo", lo, 128);

    // randomized ratio / enable traffic against the model
    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 9) != 0), W'($urandom_range(0, 15)));
      repeat ($urandom_range(1, 20)) @(posedge clk);
    end
    repeat (40) @(posedge clk);
    @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
